imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL provide parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 SHALL provide parameter TAG_W, default 5, width of the sideband tag carried with each immediate.
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port flush  input  1  synchronous discard of all buffered entries.
REQ-006 SHALL provide port in_valid  input  1  an upstream instruction is offered.
REQ-007 SHALL provide port in_ready  output  1  the block accepts this cycle.
REQ-008 SHALL provide port in_instr  input  32  raw instruction word.
REQ-009 SHALL provide port in_sel  input  3  immediate type selector.
REQ-010 SHALL provide port in_tag  input  TAG_W  sideband tag, passed through unchanged.
REQ-011 SHALL provide port out_valid  output  1  out_imm and out_tag are valid.
REQ-012 SHALL provide port out_ready  input  1  downstream accepts this cycle.
REQ-013 SHALL provide port out_imm  output  XLEN  generated immediate.
REQ-014 SHALL provide port out_tag  output  TAG_W  tag of the entry on out_imm.

Function
REQ-015 SHALL decode in_sel: 000 I {sext instr[31:20]}; 001 S {sext instr[31:25],instr[11:7]}; 010 B {sext instr[31],instr[7],instr[30:25],instr[11:8],0}; 011 J {sext instr[31],instr[19:12],instr[20],instr[30:21],0}.
REQ-016 SHALL decode 100 U as {instr[31:12],12'h000} sign-extended from bit 31 to XLEN.
REQ-017 SHALL decode 101 Z (CSR zimm) as instr[19:15] zero-extended to XLEN.
REQ-018 SHALL decode 110 SHAMT as instr[25:20] (XLEN=64) or instr[24:20] (XLEN=32), zero-extended.
REQ-019 SHALL decode 111 (reserved) as all-zero.
REQ-020 SHALL sign-extend all signed types to full XLEN (bit 31 replicated into bits XLEN-1:32 when XLEN=64).
REQ-021 SHALL register the decoded immediate; a transfer (in_valid & in_ready) at edge N presents its result with out_valid=1 after edge N (latency 1 cycle).
REQ-022 SHALL buffer up to 2 entries (output register plus skid register); in_ready SHALL be a registered signal equal to "skid register empty".
REQ-023 SHALL hold out_imm/out_tag stable while out_valid=1 and out_ready=0.
REQ-024 SHALL deliver entries in strict acceptance order; no entry dropped or duplicated.
REQ-025 SHALL, on out_ready=1 with skid full, move the skid entry to the output register and reassert in_ready next cycle.
REQ-026 SHALL, with output empty or draining and skid empty, sustain one transfer per cycle (full throughput).
REQ-027 SHALL, on flush=1, clear both entries at the next edge (out_valid=0, in_ready=1); a simultaneous in_valid transfer SHALL be discarded; flush has priority over all other events.
REQ-028 SHALL treat out_ready as don't-care when out_valid=0.

Reset
REQ-029 SHALL, while rst_n=0, force out_valid=0, in_ready=0, out_imm=0, out_tag=0, both entries empty, independent of clk.
REQ-030 SHALL assert in_ready=1 on the first rising edge after rst_n deasserts; a reset mid-transfer discards all in-flight entries.

Configuration
REQ-031 SHALL, when IMMGEN_ILLEGAL_EN is defined, add port out_ill  output  1, registered with its entry, =1 when that entry's in_sel was 111; reset value 0; cleared by flush.
REQ-032 SHALL, when IMMGEN_ILLEGAL_EN is undefined, omit out_ill and treat in_sel=111 silently as an all-zero immediate.

Verification
REQ-033 SHALL test XLEN=32: instr 0xFFF00093, sel 000, tag 3 -> one cycle later out_imm=0xFFFFFFFF, out_tag=3, out_valid=1.
REQ-034 SHALL test B-type: instr 0xFE000EE3, sel 010 -> out_imm=0xFFFFFFFC; J-type instr 0x0080006F, sel 011 -> 0x00000008.
REQ-035 SHALL test XLEN=64: instr 0x80000037, sel 100 -> 0xFFFFFFFF80000000; instr 0x03F01013, sel 110 -> 0x000000000000003F.
REQ-036 SHALL test backpressure: out_ready=0, push tags 1,2,3 back-to-back -> in_ready=0 after tag 2 accepted, tag 3 held upstream; release out_ready -> tags emerge 1,2,3 on consecutive cycles.
REQ-037 SHALL test flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, no flushed tag ever appears on out_tag.
REQ-038 SHALL test with IMMGEN_ILLEGAL_EN defined: sel 111 -> out_imm=0, out_ill=1; following sel 000 entry -> out_ill=0.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate generator with a 2-entry skid-buffered valid/ready pipeline.
// Define IMMGEN_ILLEGAL_EN to add the out_ill flag marking entries decoded from the reserved selector.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag
`ifdef IMMGEN_ILLEGAL_EN
  ,
  output logic             out_ill
`endif
);
  logic [31:0]      v;
  logic             sx;
  logic [XLEN-1:0]  dec;
  logic             push;
  logic             s_valid;
  logic [XLEN-1:0]  s_imm;
  logic [TAG_W-1:0] s_tag;
`ifdef IMMGEN_ILLEGAL_EN
  logic             s_ill;
`endif
  always_comb begin
    v  = '0;
    sx = 1'b1;
    case (in_sel)
      3'd0: v = {{20{in_instr[31]}}, in_instr[31:20]};
      3'd1: v = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      3'd2: v = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      3'd3: v = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      3'd4: v = {in_instr[31:12], 12'h000};
      3'd5: begin
        v  = {27'd0, in_instr[19:15]};
        sx = 1'b0;
      end
      3'd6: begin
        v  = (XLEN == 64) ? {26'd0, in_instr[25:20]} : {27'd0, in_instr[24:20]};
        sx = 1'b0;
      end
      default: v = '0;
    endcase
    dec = sx ? XLEN'($signed(v)) : XLEN'(v);
  end
  assign push = in_valid & in_ready;
  // in_ready mirrors "skid empty" but is held low throughout reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_imm   <= '0;
      out_tag   <= '0;
      s_valid   <= 1'b0;
      s_imm     <= '0;
      s_tag     <= '0;
      in_ready  <= 1'b0;
`ifdef IMMGEN_ILLEGAL_EN
      out_ill   <= 1'b0;
      s_ill     <= 1'b0;
`endif
    end else if (flush) begin
      out_valid <= 1'b0;
      s_valid   <= 1'b0;
      in_ready  <= 1'b1;
`ifdef IMMGEN_ILLEGAL_EN
      out_ill   <= 1'b0;
      s_ill     <= 1'b0;
`endif
    end else if (!out_valid || out_ready) begin
      out_valid <= s_valid | push;
      s_valid   <= 1'b0;
      in_ready  <= 1'b1;
      if (s_valid) begin
        out_imm <= s_imm;
        out_tag <= s_tag;
`ifdef IMMGEN_ILLEGAL_EN
        out_ill <= s_ill;
`endif
      end else if (push) begin
        out_imm <= dec;
        out_tag <= in_tag;
`ifdef IMMGEN_ILLEGAL_EN
        out_ill <= in_sel == 3'b111;
`endif
      end
    end else if (push) begin
      s_valid  <= 1'b1;
      s_imm    <= dec;
      s_tag    <= in_tag;
      in_ready <= 1'b0;
`ifdef IMMGEN_ILLEGAL_EN
      s_ill    <= in_sel == 3'b111;
`endif
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed and randomized checks of imm_gen_pipe at XLEN=32 and XLEN=64 side by side.
module tb_imm_gen_pipe;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [2:0]  in_sel = '0;
  logic [4:0]  in_tag = '0;
  logic        rdy32, rdy64, v32, v64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [4:0]  tag32, tag64;
`ifdef IMMGEN_ILLEGAL_EN
  logic        ill32, ill64;
`endif
  int n_cmp = 0, n_err = 0;
  typedef struct {
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [4:0]  tag;
  } ent_t;
  ent_t q[$];

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag), .out_valid(v32),
    .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32)
`ifdef IMMGEN_ILLEGAL_EN
    , .out_ill(ill32)
`endif
  );
  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag), .out_valid(v64),
    .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64)
`ifdef IMMGEN_ILLEGAL_EN
    , .out_ill(ill64)
`endif
  );

  always #5 clk = ~clk;

  // Immediate value computed arithmetically from the field definitions
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] sel, input bit x64);
    longint sl, hi, r;
    sl = longint'($signed(ins));
    hi = sl >>> 31;
    case (sel)
      3'd0: r = sl >>> 20;
      3'd1: begin
        r = sl >>> 25;
        r = r * 32 + longint'(ins[11:7]);
      end
      3'd2: r = hi * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
      3'd3: r = hi * 1048576 + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
      3'd4: begin
        r = sl >>> 12;
        r = r * 4096;
      end
      3'd5: r = longint'(ins[19:15]);
      3'd6: r = x64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
      default: r = 0;
    endcase
    return r;
  endfunction

  task automatic test_reset;
    #1;
    n_cmp += 4;
    if (v32 !== 1'b0 || v64 !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b/%b exp 0", v32, v64); end
    if (rdy32 !== 1'b0 || rdy64 !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b/%b exp 0", rdy32, rdy64); end
    if (imm32 !== '0 || imm64 !== '0) begin n_err++; $display("FAIL reset_imm got %h/%h exp 0", imm32, imm64); end
    if (tag32 !== '0 || tag64 !== '0) begin n_err++; $display("FAIL reset_tag got %h/%h exp 0", tag32, tag64); end
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    n_cmp++;
    if (rdy32 !== 1'b0) begin n_err++; $display("FAIL ready_before_edge got %b exp 0", rdy32); end
    @(negedge clk);
    n_cmp += 2;
    if (rdy32 !== 1'b1 || rdy64 !== 1'b1) begin n_err++; $display("FAIL ready_after_reset got %b/%b exp 1", rdy32, rdy64); end
    if (v32 !== 1'b0) begin n_err++; $display("FAIL valid_after_reset got %b exp 0", v32); end
  endtask

  task automatic test_decode;
    logic [31:0] ins[8]  = '{32'hFFF00093, 32'hFE000EE3, 32'h0080006F, 32'h80000037,
                             32'h03F01013, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [2:0]  sel[8]  = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd1, 3'd7};
    logic [31:0] e32[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h8, 32'h80000000,
                             32'h1F, 32'h1F, 32'hFFFFF800, 32'h0};
    logic [63:0] e64[8]  = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h8, 64'hFFFFFFFF80000000,
                             64'h3F, 64'h1F, 64'hFFFFFFFFFFFFF800, 64'h0};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_instr = ins[i];
      in_sel   = sel[i];
      in_tag   = 5'(i + 3);
      @(negedge clk);
      n_cmp += 5;
      if (v32 !== 1'b1 || v64 !== 1'b1) begin n_err++; $display("FAIL dec%0d_valid got %b/%b exp 1", i, v32, v64); end
      if (imm32 !== e32[i]) begin n_err++; $display("FAIL dec%0d_imm32 got %h exp %h", i, imm32, e32[i]); end
      if (imm64 !== e64[i]) begin n_err++; $display("FAIL dec%0d_imm64 got %h exp %h", i, imm64, e64[i]); end
      if (tag32 !== 5'(i + 3) || tag64 !== 5'(i + 3)) begin n_err++; $display("FAIL dec%0d_tag got %0d/%0d exp %0d", i, tag32, tag64, i + 3); end
      if (imm64 !== ref_imm(ins[i], sel[i], 1'b1)) begin n_err++; $display("FAIL dec%0d_model got %h exp %h", i, imm64, ref_imm(ins[i], sel[i], 1'b1)); end
`ifdef IMMGEN_ILLEGAL_EN
      n_cmp++;
      if (ill32 !== (sel[i] == 3'd7) || ill64 !== (sel[i] == 3'd7)) begin n_err++; $display("FAIL dec%0d_ill got %b/%b exp %b", i, ill32, ill64, sel[i] == 3'd7); end
`endif
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (v32 !== 1'b0) begin n_err++; $display("FAIL dec_drain got %b exp 0", v32); end
  endtask

  task automatic test_backpressure;
    int exp_t[7] = '{1, 1, 1, 2, 3, 0, 0};
    bit exp_r[7] = '{1, 0, 0, 1, 1, 1, 1};
    bit exp_v[7] = '{1, 1, 1, 1, 1, 0, 0};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093;
    in_sel    = 3'd0;
    in_tag    = 5'd1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_cmp += 3;
      if (v32 !== exp_v[i]) begin n_err++; $display("FAIL bp%0d_valid got %b exp %b", i, v32, exp_v[i]); end
      if (rdy32 !== exp_r[i] || rdy64 !== exp_r[i]) begin n_err++; $display("FAIL bp%0d_ready got %b/%b exp %b", i, rdy32, rdy64, exp_r[i]); end
      if (exp_v[i] && tag32 !== 5'(exp_t[i])) begin n_err++; $display("FAIL bp%0d_tag got %0d exp %0d", i, tag32, exp_t[i]); end
      if (i == 0) in_tag = 5'd2;
      if (i == 1) in_tag = 5'd3;
      if (i == 2) out_ready = 1'b1;
      if (i == 4) in_valid = 1'b0;
    end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 3'd0;
    in_tag    = 5'd4;
    @(negedge clk);
    in_tag = 5'd5;
    @(negedge clk);
    n_cmp++;
    if (rdy32 !== 1'b0) begin n_err++; $display("FAIL flush_full got ready %b exp 0", rdy32); end
    in_tag = 5'd6;
    flush  = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp += 2;
    if (v32 !== 1'b0 || v64 !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b/%b exp 0", v32, v64); end
    if (rdy32 !== 1'b1 || rdy64 !== 1'b1) begin n_err++; $display("FAIL flush_ready got %b/%b exp 1", rdy32, rdy64); end
    in_tag = 5'd7;
    @(negedge clk);
    in_tag = 5'd8;
    flush  = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (v32 !== 1'b0) begin n_err++; $display("FAIL flush_leak%0d got valid %b tag %0d exp 0", i, v32, tag32); end
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    bit   ev, er, pop, push;
    ent_t e;
    logic [63:0] r64;
    q.delete();
    for (int c = 0; c < 400; c++) begin
      ev = q.size() > 0;
      er = q.size() < 2;
      n_cmp += 3;
      if (v32 !== ev || v64 !== ev) begin n_err++; $display("FAIL rnd%0d_valid got %b/%b exp %b", c, v32, v64, ev); end
      if (rdy32 !== er || rdy64 !== er) begin n_err++; $display("FAIL rnd%0d_ready got %b/%b exp %b", c, rdy32, rdy64, er); end
      if (ev) begin
        r64 = ref_imm(q[0].instr, q[0].sel, 1'b1);
        if (imm64 !== r64 || tag64 !== q[0].tag) begin n_err++; $display("FAIL rnd%0d_out64 got %h/%0d exp %h/%0d", c, imm64, tag64, r64, q[0].tag); end
        r64 = ref_imm(q[0].instr, q[0].sel, 1'b0);
        n_cmp++;
        if (imm32 !== r64[31:0] || tag32 !== q[0].tag) begin n_err++; $display("FAIL rnd%0d_out32 got %h/%0d exp %h/%0d", c, imm32, tag32, r64[31:0], q[0].tag); end
      end
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      flush     = $urandom_range(0, 24) == 0;
      in_instr  = $urandom;
      in_sel    = 3'($urandom_range(0, 7));
      in_tag    = 5'($urandom);
      @(posedge clk);
      if (flush) q.delete();
      else begin
        pop  = q.size() > 0 && out_ready;
        push = in_valid && q.size() < 2;
        e = '{in_instr, in_sel, in_tag};
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tag    = 5'd9;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp += 2;
    if (v32 !== 1'b0 || rdy32 !== 1'b0) begin n_err++; $display("FAIL rstmid_async got valid %b ready %b exp 0/0", v32, rdy32); end
    if (imm64 !== '0 || tag64 !== '0) begin n_err++; $display("FAIL rstmid_data got %h/%0d exp 0/0", imm64, tag64); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp += 2;
    if (rdy32 !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got %b exp 1", rdy32); end
    if (v32 !== 1'b0 || v64 !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %b/%b exp 0", v32, v64); end
  endtask

  initial begin
    test_reset;
    test_decode;
    test_backpressure;
    test_flush;
    test_random;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
